cmd_wb_master: RTL and testbench
================================

# cmd_wb_master

Command-word driven Wishbone master with a buffered response path: the parametrised successor of the CPU's fixed 34-bit `cmd_*`/`rsp_*` memory-access interface. Accepts one command word per handshake, performs single Wishbone classic-pipelined reads and writes at an internal address register with optional auto-increment, and queues responses in a parametrised FIFO with host back-pressure. It sits between the multi-cycle core (or a debug host) and the memory bus.

## Interface
- `DW`, 32, data width; multiple of 8. Command/response word width is `CW = DW+2`.
- `AW`, 32, word-address width; `AW <= DW`.
- `FIFO_DEPTH`, 4, response FIFO entries; power of two, >= 2.
- `TIMEOUT_CYCLES`, 255, bus watchdog limit; used only with the macro in Configuration.
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `cmd_stb`  in  1  command valid.
- `cmd_word`  in  CW  `[CW-1:CW-2]` opcode, `[DW-1:0]` payload.
- `cmd_busy`  out  1  command not accepted this cycle.
- `rsp_stb`  out  1  response valid (FIFO non-empty).
- `rsp_word`  out  CW  FIFO head: `[CW-1:CW-2]` code, `[DW-1:0]` payload.
- `rsp_ready`  in  1  host pops head when `rsp_stb & rsp_ready`.
- `wb_cyc`, `wb_stb`, `wb_we`  out  1  Wishbone cycle, strobe, write enable.
- `wb_addr`  out  AW  word address.
- `wb_data_w`  out  DW  write data.
- `wb_sel`  out  DW/8  byte selects; constant all-ones.
- `wb_stall`, `wb_ack`, `wb_err`  in  1  Wishbone stall, acknowledge, error.
- `wb_data_r`  in  DW  read data.

## Operation
- Opcodes: `00` SET_ADDR_INC (addr <= payload[AW-1:0], inc <= 1); `11` SET_ADDR_FIX (same, inc <= 0); `01` READ; `10` WRITE (data = payload).
- Response codes: `00` write ack, payload 0; `01` read data; `10` address echo, payload = new addr zero-extended; `11` bus error/timeout, payload = faulting addr.
- FSM states: IDLE, REQ, WAIT, PUSH.
  - IDLE: accept on `cmd_stb & !cmd_busy`. READ/WRITE -> REQ; SET_ADDR -> PUSH.
  - REQ: `wb_cyc=wb_stb=1`; leave to WAIT on the first cycle with `!wb_stall`. If `wb_ack` or `wb_err` arrives in that same cycle, go directly to PUSH.
  - WAIT: `wb_cyc=1`, `wb_stb=0`; on `wb_ack` or `wb_err` -> PUSH. If both are high, `wb_err` wins.
  - PUSH: write one response into the FIFO, return to IDLE.
- `cmd_busy = (state != IDLE) | fifo_full`. Commands are accepted only when a free entry exists, so PUSH never overflows.
- Address update on ack: if inc=1, addr <= addr+1 modulo 2^AW (`{AW{1}}` wraps to 0). On error, addr is unchanged.
- FIFO: simultaneous push and pop keeps the count constant. A pop when empty is ignored.
- Reset values: `wb_cyc=wb_stb=wb_we=0`, `wb_addr=0`, `wb_data_w=0`, `cmd_busy=0`, `rsp_stb=0`, `rsp_word=0`, FIFO empty, addr=0, inc=1.
- Reset asserted mid-transaction drops `wb_cyc` immediately and discards the in-flight response and all queued responses.

## Timing
- Command accepted at edge N: `wb_stb` is high from cycle N+1.
- Ack sampled at edge M: the response is written at edge M+1. `rsp_stb` is high from cycle M+1 if the FIFO was empty.
- SET_ADDR: response visible 2 cycles after acceptance.
- Zero-stall, same-cycle-ack read: 3 cycles from acceptance to `rsp_stb`. Next command accepted at the earliest 3 cycles after the previous one.
- `rsp_word` is always the registered FIFO head; no combinational path from `wb_*` to `rsp_*`.

## Configuration
- `CMD_WB_TIMEOUT_EN` defined:
  - A counter clears on entry to REQ and increments each cycle in REQ/WAIT.
  - When it reaches `TIMEOUT_CYCLES` with no ack/err, `wb_cyc`/`wb_stb` drop on the next edge.
  - A code `11` response with the current addr is pushed; addr is not incremented.
- Undefined: no counter; the master waits indefinitely for ack/err.

## Test plan
- Reset, then SET_ADDR_INC 0x100 -> rsp `{10, 0x100}` after 2 cycles; all Wishbone outputs 0 during and after reset.
- WRITE 0xDEADBEEF, then READ, with slave ack next cycle -> `wb_addr` 0x100 for the write, then 0x101 for the read; rsps `{00,0}`, `{01,<slave data>}`; addr = 0x102.
- SET_ADDR_FIX 0x20, 3 READs with `wb_stall` high 4 cycles on the first -> all three at 0x20; `wb_stb` held through the stall.
- Hold `rsp_ready=0`, issue `FIFO_DEPTH` READs -> `cmd_busy` stays high after the 4th push; one pop releases exactly one command. SET_ADDR_INC `{AW{1}}` plus a READ wraps addr to 0.
- `wb_err` on a WRITE -> rsp `{11, addr}`, addr unchanged. With `CMD_WB_TIMEOUT_EN` and `TIMEOUT_CYCLES`=8, no ack -> `wb_cyc` low and `{11, addr}` pushed after 8 cycles.
- Assert `reset` in WAIT with 2 queued responses -> `wb_cyc` low asynchronously; FIFO empty and `rsp_stb`=0 after release.

Source files
------------

// File: rtl/cmd_wb_master_if.sv
// Command/response handshake plus Wishbone classic-pipelined bus for cmd_wb_master.
// master modport is the block's view; slave modport is the host/bus-side view.
interface cmd_wb_master_if #(
    parameter int DW = 32,
    parameter int AW = 32
);
    localparam int CW = DW + 2;

    logic            cmd_stb;
    logic [CW-1:0]   cmd_word;
    logic            cmd_busy;
    logic            rsp_stb;
    logic [CW-1:0]   rsp_word;
    logic            rsp_ready;

    logic            wb_cyc;
    logic            wb_stb;
    logic            wb_we;
    logic [AW-1:0]   wb_addr;
    logic [DW-1:0]   wb_data_w;
    logic [DW/8-1:0] wb_sel;
    logic            wb_stall;
    logic            wb_ack;
    logic            wb_err;
    logic [DW-1:0]   wb_data_r;

    modport master (
        input  cmd_stb, cmd_word, rsp_ready, wb_stall, wb_ack, wb_err, wb_data_r,
        output cmd_busy, rsp_stb, rsp_word, wb_cyc, wb_stb, wb_we, wb_addr, wb_data_w, wb_sel
    );

    modport slave (
        output cmd_stb, cmd_word, rsp_ready, wb_stall, wb_ack, wb_err, wb_data_r,
        input  cmd_busy, rsp_stb, rsp_word, wb_cyc, wb_stb, wb_we, wb_addr, wb_data_w, wb_sel
    );
endinterface

// File: rtl/cmd_wb_master.sv
// Command-word driven Wishbone master with a response FIFO and host back-pressure.
// Optional bus watchdog enabled by defining CMD_WB_TIMEOUT_EN.
module cmd_wb_master #(
    parameter int DW             = 32,
    parameter int AW             = 32,
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input logic             clk,
    input logic             reset,
    cmd_wb_master_if.master bus
);
    localparam int CW = DW + 2;
    localparam int PW = $clog2(FIFO_DEPTH);

    localparam logic [1:0] OP_INC = 2'b00, OP_READ = 2'b01, OP_WRITE = 2'b10;
    localparam logic [1:0] RSP_WACK = 2'b00, RSP_RDATA = 2'b01, RSP_ADDR = 2'b10, RSP_ERR = 2'b11;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, PUSH} state_t;

    generate
        if ((DW % 8) != 0 || AW > DW || FIFO_DEPTH < 2 ||
            (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 1) begin : g_bad_param
            $error("cmd_wb_master: illegal parameter combination");
        end
    endgenerate

    state_t          state;
    logic [AW-1:0]   addr;
    logic            inc;
    logic [1:0]      pend_code;
    logic [DW-1:0]   pend_pay;
    logic            wb_cyc, wb_stb, wb_we;
    logic [AW-1:0]   wb_addr;
    logic [DW-1:0]   wb_data_w;

    logic [CW-1:0]   mem [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [PW:0]     count;

    logic [1:0]      op;
    logic [DW-1:0]   pay;
    logic            fifo_full, busy, accept, bus_done, push, pop;

    assign op        = bus.cmd_word[CW-1:CW-2];
    assign pay       = bus.cmd_word[DW-1:0];
    assign fifo_full = (count == (PW+1)'(FIFO_DEPTH));
    assign busy      = (state != IDLE) | fifo_full;
    assign accept    = bus.cmd_stb & ~busy;
    // An ack/err only completes the request once the slave has taken the strobe.
    assign bus_done  = (bus.wb_ack | bus.wb_err) & ((state == WAIT) | ~bus.wb_stall);
    assign push      = (state == PUSH);
    assign pop       = (count != '0) & bus.rsp_ready;

    assign bus.cmd_busy  = busy;
    assign bus.rsp_stb   = (count != '0);
    assign bus.rsp_word  = mem[rd_ptr];
    assign bus.wb_cyc    = wb_cyc;
    assign bus.wb_stb    = wb_stb;
    assign bus.wb_we     = wb_we;
    assign bus.wb_addr   = wb_addr;
    assign bus.wb_data_w = wb_data_w;
    assign bus.wb_sel    = '1;

`ifdef CMD_WB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmo_cnt;
    logic          tmo;
    assign tmo = (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            addr      <= '0;
            inc       <= 1'b1;
            pend_code <= '0;
            pend_pay  <= '0;
            wb_cyc    <= 1'b0;
            wb_stb    <= 1'b0;
            wb_we     <= 1'b0;
            wb_addr   <= '0;
            wb_data_w <= '0;
`ifdef CMD_WB_TIMEOUT_EN
            tmo_cnt   <= '0;
`endif
        end else begin
            case (state)
                IDLE: if (accept) begin
                    if (op == OP_READ || op == OP_WRITE) begin
                        wb_cyc  <= 1'b1;
                        wb_stb  <= 1'b1;
                        wb_we   <= (op == OP_WRITE);
                        wb_addr <= addr;
                        if (op == OP_WRITE) wb_data_w <= pay;
`ifdef CMD_WB_TIMEOUT_EN
                        tmo_cnt <= '0;
`endif
                        state   <= REQ;
                    end else begin
                        addr      <= pay[AW-1:0];
                        inc       <= (op == OP_INC);
                        pend_code <= RSP_ADDR;
                        pend_pay  <= DW'(pay[AW-1:0]);
                        state     <= PUSH;
                    end
                end
                REQ, WAIT: begin
`ifdef CMD_WB_TIMEOUT_EN
                    tmo_cnt <= tmo_cnt + 1'b1;
`endif
                    if (bus_done) begin
                        wb_cyc <= 1'b0;
                        wb_stb <= 1'b0;
                        state  <= PUSH;
                        if (bus.wb_err) begin
                            pend_code <= RSP_ERR;
                            pend_pay  <= DW'(addr);
                        end else begin
                            pend_code <= wb_we ? RSP_WACK : RSP_RDATA;
                            pend_pay  <= wb_we ? '0 : bus.wb_data_r;
                            if (inc) addr <= addr + AW'(1);
                        end
                    end
`ifdef CMD_WB_TIMEOUT_EN
                    else if (tmo) begin
                        wb_cyc    <= 1'b0;
                        wb_stb    <= 1'b0;
                        pend_code <= RSP_ERR;
                        pend_pay  <= DW'(addr);
                        state     <= PUSH;
                    end
`endif
                    else if (state == REQ && !bus.wb_stall) begin
                        wb_stb <= 1'b0;
                        state  <= WAIT;
                    end
                end
                PUSH:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Busy gating guarantees a free slot whenever PUSH is reached.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= {pend_code, pend_pay};
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: tb/tb_cmd_wb_master.sv
// Directed bench for cmd_wb_master: address echo, read/write, stall, back-pressure,
// wrap, bus error, optional watchdog and mid-transaction reset.
module tb_cmd_wb_master;
    localparam int DW = 32, AW = 32, DEPTH = 4;
    localparam logic [1:0] OP_INC = 2'b00, OP_READ = 2'b01, OP_WRITE = 2'b10, OP_FIX = 2'b11;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   vectors = 0;
    int   errs = 0;

    cmd_wb_master_if #(.DW(DW), .AW(AW)) bus();

    cmd_wb_master #(.DW(DW), .AW(AW), .FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [1:0] op, input logic [31:0] pay);
        int n = 0;
        bus.cmd_word = {op, pay};
        bus.cmd_stb  = 1'b1;
        while (bus.cmd_busy && n < 50) begin
            tick();
            n++;
        end
        chk("accept_in_budget", 64'(n < 50), 64'd1);
        tick();
        bus.cmd_stb = 1'b0;
    endtask

    task automatic pop_check(input string tag, input logic [33:0] exp);
        chk({tag, "_stb"}, 64'(bus.rsp_stb), 64'd1);
        chk({tag, "_word"}, 64'(bus.rsp_word), 64'(exp));
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
    endtask

    // One bus command: stall cycles in REQ, then wait_n extra cycles before ack/err.
    task automatic xact(input logic [1:0] op, input logic [31:0] pay, input int stall_n,
                        input int wait_n, input logic err, input logic [31:0] rdata,
                        input logic [31:0] exp_addr);
        send(op, pay);
        chk("req_stb", 64'(bus.wb_stb), 64'd1);
        chk("req_addr", 64'(bus.wb_addr), 64'(exp_addr));
        chk("req_we", 64'(bus.wb_we), 64'(op == OP_WRITE));
        if (op == OP_WRITE) chk("req_wdata", 64'(bus.wb_data_w), 64'(pay));
        bus.wb_stall = (stall_n > 0);
        for (int i = 0; i < stall_n; i++) begin
            tick();
            chk("stall_stb_held", 64'(bus.wb_stb), 64'd1);
        end
        bus.wb_stall = 1'b0;
        if (wait_n > 0) begin
            tick();
            chk("wait_stb", 64'(bus.wb_stb), 64'd0);
            chk("wait_cyc", 64'(bus.wb_cyc), 64'd1);
            for (int i = 1; i < wait_n; i++) tick();
        end
        if (err) bus.wb_err = 1'b1;
        else     bus.wb_ack = 1'b1;
        bus.wb_data_r = rdata;
        tick();
        bus.wb_ack = 1'b0;
        bus.wb_err = 1'b0;
        chk("done_cyc", 64'(bus.wb_cyc), 64'd0);
        tick();
    endtask

    initial begin
        bus.cmd_stb   = 1'b1;
        bus.cmd_word  = {OP_READ, 32'h0};
        bus.rsp_ready = 1'b0;
        bus.wb_stall  = 1'b0;
        bus.wb_ack    = 1'b0;
        bus.wb_err    = 1'b0;
        bus.wb_data_r = '0;
        tick();
        tick();
        chk("rst_cyc", 64'(bus.wb_cyc), 64'd0);
        chk("rst_stb", 64'(bus.wb_stb), 64'd0);
        chk("rst_we", 64'(bus.wb_we), 64'd0);
        chk("rst_addr", 64'(bus.wb_addr), 64'd0);
        chk("rst_wdata", 64'(bus.wb_data_w), 64'd0);
        chk("rst_busy", 64'(bus.cmd_busy), 64'd0);
        chk("rst_rsp_stb", 64'(bus.rsp_stb), 64'd0);
        chk("rst_rsp_word", 64'(bus.rsp_word), 64'd0);
        chk("rst_sel", 64'(bus.wb_sel), 64'hF);
        bus.cmd_stb = 1'b0;
        reset = 1'b1;

        // Address echo: empty one cycle after acceptance, valid the next.
        send(OP_INC, 32'h100);
        chk("setaddr_rsp_early", 64'(bus.rsp_stb), 64'd0);
        chk("setaddr_cyc", 64'(bus.wb_cyc), 64'd0);
        tick();
        chk("setaddr_after_cyc", 64'(bus.wb_cyc), 64'd0);
        pop_check("setaddr_100", {2'b10, 32'h100});
        chk("fifo_empty_after_pop", 64'(bus.rsp_stb), 64'd0);

        xact(OP_WRITE, 32'hDEADBEEF, 0, 0, 1'b0, 32'h0, 32'h100);
        pop_check("write_ack", {2'b00, 32'h0});
        xact(OP_READ, 32'h0, 0, 1, 1'b0, 32'hCAFEF00D, 32'h101);
        pop_check("read_data", {2'b01, 32'hCAFEF00D});
        xact(OP_READ, 32'h0, 0, 0, 1'b0, 32'h11111111, 32'h102);
        pop_check("read_102", {2'b01, 32'h11111111});

        // Fixed address with a stalled first read.
        send(OP_FIX, 32'h20);
        tick();
        pop_check("setfix_20", {2'b10, 32'h20});
        xact(OP_READ, 32'h0, 4, 1, 1'b0, 32'hA0A0A0A0, 32'h20);
        pop_check("fix_rd0", {2'b01, 32'hA0A0A0A0});
        xact(OP_READ, 32'h0, 0, 0, 1'b0, 32'hA1A1A1A1, 32'h20);
        pop_check("fix_rd1", {2'b01, 32'hA1A1A1A1});
        xact(OP_READ, 32'h0, 0, 1, 1'b0, 32'hA2A2A2A2, 32'h20);
        pop_check("fix_rd2", {2'b01, 32'hA2A2A2A2});

        // Back-pressure: fill the FIFO, then a single pop admits a single command.
        send(OP_INC, 32'h40);
        tick();
        pop_check("setaddr_40", {2'b10, 32'h40});
        for (int i = 0; i < DEPTH; i++)
            xact(OP_READ, 32'h0, 0, 0, 1'b0, 32'hB000_0000 + 32'(i), 32'h40 + 32'(i));
        chk("full_busy", 64'(bus.cmd_busy), 64'd1);
        bus.cmd_word = {OP_READ, 32'h0};
        bus.cmd_stb  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("full_hold_busy", 64'(bus.cmd_busy), 64'd1);
            chk("full_hold_cyc", 64'(bus.wb_cyc), 64'd0);
        end
        bus.cmd_stb = 1'b0;
        pop_check("full_pop0", {2'b01, 32'hB0000000});
        chk("busy_release", 64'(bus.cmd_busy), 64'd0);
        xact(OP_READ, 32'h0, 0, 0, 1'b0, 32'h55555555, 32'h44);
        chk("refull_busy", 64'(bus.cmd_busy), 64'd1);
        pop_check("full_pop1", {2'b01, 32'hB0000001});
        pop_check("full_pop2", {2'b01, 32'hB0000002});
        pop_check("full_pop3", {2'b01, 32'hB0000003});
        pop_check("full_pop4", {2'b01, 32'h55555555});
        chk("drained", 64'(bus.rsp_stb), 64'd0);

        // Address wrap.
        send(OP_INC, 32'hFFFFFFFF);
        tick();
        pop_check("setaddr_max", {2'b10, 32'hFFFFFFFF});
        xact(OP_READ, 32'h0, 0, 0, 1'b0, 32'h77777777, 32'hFFFFFFFF);
        pop_check("wrap_rd_max", {2'b01, 32'h77777777});
        xact(OP_READ, 32'h0, 0, 0, 1'b0, 32'h88888888, 32'h0);
        pop_check("wrap_rd_0", {2'b01, 32'h88888888});

        // Bus error leaves the address untouched.
        xact(OP_WRITE, 32'h12345678, 0, 1, 1'b1, 32'h0, 32'h1);
        pop_check("err_rsp", {2'b11, 32'h1});
        xact(OP_READ, 32'h0, 0, 0, 1'b0, 32'h99999999, 32'h1);
        pop_check("after_err_rd", {2'b01, 32'h99999999});

`ifdef CMD_WB_TIMEOUT_EN
        send(OP_READ, 32'h0);
        chk("tmo_addr", 64'(bus.wb_addr), 64'h2);
        for (int i = 0; i < 7; i++) tick();
        chk("tmo_cyc_still_high", 64'(bus.wb_cyc), 64'd1);
        tick();
        chk("tmo_cyc_dropped", 64'(bus.wb_cyc), 64'd0);
        tick();
        pop_check("tmo_rsp", {2'b11, 32'h2});
`endif

        // Reset in WAIT with two queued responses.
        xact(OP_READ, 32'h0, 0, 0, 1'b0, 32'hC0C0C0C0, 32'h2);
        xact(OP_READ, 32'h0, 0, 0, 1'b0, 32'hC1C1C1C1, 32'h3);
        send(OP_READ, 32'h0);
        tick();
        chk("pre_rst_cyc", 64'(bus.wb_cyc), 64'd1);
        chk("pre_rst_rsp_stb", 64'(bus.rsp_stb), 64'd1);
        #2 reset = 1'b0;
        #1;
        chk("async_rst_cyc", 64'(bus.wb_cyc), 64'd0);
        chk("async_rst_rsp_stb", 64'(bus.rsp_stb), 64'd0);
        @(negedge clk) reset = 1'b1;
        tick();
        chk("post_rst_rsp_stb", 64'(bus.rsp_stb), 64'd0);
        chk("post_rst_busy", 64'(bus.cmd_busy), 64'd0);
        chk("post_rst_cyc", 64'(bus.wb_cyc), 64'd0);
        xact(OP_READ, 32'h0, 0, 0, 1'b0, 32'hD00DD00D, 32'h0);
        pop_check("post_rst_rd", {2'b01, 32'hD00DD00D});

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
